// File: rtl/sel_mux_pipe_pkg.sv
// Shared mode encodings and round-robin pointer helper for the sel_mux_pipe family.
package sel_mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Pointer advance past the granted channel, wrapping at the last channel.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/sel_mux_pipe_if.sv
// Handshake/data bundle between producers, the select mux and its consumer.
// Optional SEL_MUX_PARITY_EN adds in_par, out_par and par_err.
interface sel_mux_pipe_if #(
  parameter int unsigned N_CH  = 10,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEL_W = 7
);
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [N_CH*WIDTH-1:0]   in_data;
  logic [N_CH-1:0]         in_valid;
  logic [N_CH-1:0]         in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_ch;
  logic                    sel_err;
  logic                    err_clr;
`ifdef SEL_MUX_PARITY_EN
  logic [N_CH-1:0]         in_par;
  logic                    out_par;
  logic                    par_err;
`endif

  modport master (
    output mode, sel, in_data, in_valid, out_ready, err_clr,
`ifdef SEL_MUX_PARITY_EN
    output in_par,
    input  out_par, par_err,
`endif
    input  in_ready, out_data, out_valid, out_ch, sel_err
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready, err_clr,
`ifdef SEL_MUX_PARITY_EN
    input  in_par,
    output out_par, par_err,
`endif
    output in_ready, out_data, out_valid, out_ch, sel_err
  );
endinterface

// File: rtl/sel_mux_pipe_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
// Expects ptr_i < N.
module rr_pick #(
  parameter int unsigned N     = 10,
  parameter int unsigned IDX_W = 7
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             grant_vld_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  // Smallest rotational distance from the pointer wins.
  always_comb begin
    int unsigned p;
    int unsigned d;
    int unsigned best;
    grant_vld_o = 1'b0;
    grant_idx_o = '0;
    p           = 32'(ptr_i);
    best        = N;
    d           = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i]) begin
        d = (i >= p) ? (i - p) : (i + N - p);
        if (d < best) begin
          best        = d;
          grant_vld_o = 1'b1;
          grant_idx_o = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sel_mux_pipe.sv
// Registered N-channel select mux with valid/ready handshakes, directed or round-robin select.
// Define SEL_MUX_PARITY_EN to add per-channel parity check and output parity.
module sel_mux_pipe
  import sel_mux_pkg::*;
#(
  parameter int unsigned N_CH  = 10,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEL_W = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  sel_mux_pipe_if.slave bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_c, xfer_c, err_set_c, sel_oor_c;
  logic             dir_vld_c, rr_vld_c, grant_vld_c;
  logic [SEL_W-1:0] rr_idx_c, grant_idx_c;
  logic [WIDTH-1:0] grant_data_c;
  logic [N_CH-1:0]  in_ready_c;

  rr_pick #(.N(N_CH), .IDX_W(SEL_W)) u_rr_pick (
    .req_i       (bus.in_valid),
    .ptr_i       (ptr_q),
    .grant_vld_o (rr_vld_c),
    .grant_idx_o (rr_idx_c)
  );

  assign load_c    = !out_valid_q || bus.out_ready;
  assign sel_oor_c = 32'(bus.sel) >= N_CH;

  always_comb begin
    dir_vld_c = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++)
      if (bus.sel == SEL_W'(i) && bus.in_valid[i]) dir_vld_c = 1'b1;
  end

  assign grant_vld_c = (bus.mode == MODE_RR) ? rr_vld_c : dir_vld_c;
  assign grant_idx_c = (bus.mode == MODE_RR) ? rr_idx_c : bus.sel;
  assign xfer_c      = load_c && grant_vld_c;
  assign err_set_c   = load_c && (bus.mode == MODE_DIRECT) && sel_oor_c;

  always_comb begin
    grant_data_c = '0;
    in_ready_c   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant_idx_c == SEL_W'(i)) grant_data_c = bus.in_data[i*WIDTH +: WIDTH];
      in_ready_c[i] = xfer_c && (grant_idx_c == SEL_W'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    ptr_d       = ptr_q;
    if (bus.err_clr) sel_err_d = 1'b0;
    if (err_set_c)   sel_err_d = 1'b1;
    if (load_c) begin
      if (grant_vld_c) begin
        out_data_d  = grant_data_c;
        out_ch_d    = grant_idx_c;
        out_valid_d = 1'b1;
        if (bus.mode == MODE_RR) ptr_d = SEL_W'(rr_next(32'(grant_idx_c), N_CH));
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;

`ifdef SEL_MUX_PARITY_EN
  logic out_par_q, out_par_d, par_err_q, par_err_d, grant_par_c;

  always_comb begin
    grant_par_c = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++)
      if (grant_idx_c == SEL_W'(i)) grant_par_c = bus.in_par[i];
  end

  always_comb begin
    out_par_d = out_par_q;
    par_err_d = par_err_q;
    if (bus.err_clr) par_err_d = 1'b0;
    if (xfer_c) begin
      out_par_d = ^grant_data_c;
      if (grant_par_c != ^grant_data_c) par_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      out_par_q <= out_par_d;
      par_err_q <= par_err_d;
    end
  end

  assign bus.out_par = out_par_q;
  assign bus.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Self-checking bench for sel_mux_pipe: directed scenarios plus randomized run against a queue-free scoreboard model.
module tb_sel_mux_pipe;
  localparam int unsigned N_CH  = 10;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned SEL_W = 7;

  logic clk;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  // Reference model state
  bit              m_ov;
  bit [WIDTH-1:0]  m_od;
  int              m_och;
  bit              m_err;
  int              m_ptr;

  sel_mux_pipe_if #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  sel_mux_pipe #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_ov = 0; m_od = '0; m_och = 0; m_err = 0; m_ptr = 0;
  endtask

  task automatic model_grant(output bit gv, output int g);
    int s;
    int c;
    gv = 0; g = 0;
    if (bus.mode == 1'b0) begin
      s = int'(bus.sel);
      if (s < int'(N_CH) && ((bus.in_valid >> s) & 10'd1) != 0) begin gv = 1; g = s; end
    end else begin
      for (int k = 0; k < int'(N_CH); k++) begin
        c = (m_ptr + k) % int'(N_CH);
        if (!gv && ((bus.in_valid >> c) & 10'd1) != 0) begin gv = 1; g = c; end
      end
    end
  endtask

  task automatic model_ready(output bit [N_CH-1:0] r);
    bit gv; int g;
    model_grant(gv, g);
    r = '0;
    if ((!m_ov || bus.out_ready) && gv) r = N_CH'(1) << g;
  endtask

  task automatic model_clock();
    bit gv; int g; bit load;
    model_grant(gv, g);
    load = !m_ov || bus.out_ready;
    if (bus.err_clr) m_err = 0;
    if (load && bus.mode == 1'b0 && int'(bus.sel) >= int'(N_CH)) m_err = 1;
    if (load) begin
      if (gv) begin
        m_od  = WIDTH'(bus.in_data >> (g * int'(WIDTH)));
        m_och = g;
        m_ov  = 1;
        if (bus.mode == 1'b1) m_ptr = (g + 1) % int'(N_CH);
      end else begin
        m_ov = 0;
      end
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_counting_data();
    for (int i = 0; i < int'(N_CH); i++) bus.in_data[i*WIDTH +: WIDTH] = 16'h1000 + 16'(i);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mode = 1'b0; bus.sel = '0; bus.in_data = '0; bus.in_valid = '0;
    bus.out_ready = 1'b0; bus.err_clr = 1'b0;
`ifdef SEL_MUX_PARITY_EN
    bus.in_par = '0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 16'h0) $display("FAIL reset_out_data got %h want 0000", bus.out_data); else passed++;
    total++; if (bus.out_ch !== 7'd0) $display("FAIL reset_out_ch got %0d want 0", bus.out_ch); else passed++;
    total++; if (bus.sel_err !== 1'b0) $display("FAIL reset_sel_err got %b want 0", bus.sel_err); else passed++;
    total++; if (bus.in_ready !== 10'b0) $display("FAIL reset_in_ready got %b want 0", bus.in_ready); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    set_counting_data();
    bus.in_valid = '1; bus.out_ready = 1'b1; bus.mode = 1'b0; bus.sel = 7'd3;
    #1;
    total++; if (bus.in_ready !== 10'b0000001000) $display("FAIL dir_in_ready got %b want 0000001000", bus.in_ready); else passed++;
    tick();
    total++; if (bus.out_data !== 16'h1003) $display("FAIL dir_out_data got %h want 1003", bus.out_data); else passed++;
    total++; if (bus.out_ch !== 7'd3) $display("FAIL dir_out_ch got %0d want 3", bus.out_ch); else passed++;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL dir_out_valid got %b want 1", bus.out_valid); else passed++;
  endtask

  task automatic test_sel_err();
    bus.sel = 7'd10;
    #1;
    total++; if (bus.in_ready !== 10'b0) $display("FAIL oor_in_ready got %b want 0", bus.in_ready); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL oor_out_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.sel_err !== 1'b1) $display("FAIL oor_sel_err got %b want 1", bus.sel_err); else passed++;
    total++; if (bus.out_data !== 16'h1003) $display("FAIL oor_hold_data got %h want 1003", bus.out_data); else passed++;
    bus.err_clr = 1'b1;
    tick();
    total++; if (bus.sel_err !== 1'b1) $display("FAIL err_set_wins got %b want 1", bus.sel_err); else passed++;
    bus.sel = 7'd2;
    tick();
    total++; if (bus.sel_err !== 1'b0) $display("FAIL err_clear got %b want 0", bus.sel_err); else passed++;
    total++; if (bus.out_data !== 16'h1002) $display("FAIL err_clear_data got %h want 1002", bus.out_data); else passed++;
    bus.err_clr = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_ch[5] = '{0, 5, 9, 0, 5};
    bus.mode = 1'b1; bus.in_valid = 10'b1000100001; bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (bus.out_ch !== SEL_W'(exp_ch[k]) || bus.out_valid !== 1'b1)
        $display("FAIL rr_seq[%0d] got ch=%0d v=%b want ch=%0d v=1", k, bus.out_ch, bus.out_valid, exp_ch[k]);
      else passed++;
    end
  endtask

  task automatic test_back_pressure();
    int exp_ch[2] = '{0, 5};
    tick();
    total++; if (bus.out_ch !== 7'd9) $display("FAIL bp_first got %0d want 9", bus.out_ch); else passed++;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (bus.in_ready !== 10'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", k, bus.in_ready); else passed++;
      tick();
      total++;
      if (bus.out_ch !== 7'd9 || bus.out_data !== 16'h1009 || bus.out_valid !== 1'b1)
        $display("FAIL bp_hold[%0d] got ch=%0d d=%h v=%b want ch=9 d=1009 v=1", k, bus.out_ch, bus.out_data, bus.out_valid);
      else passed++;
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (bus.out_ch !== SEL_W'(exp_ch[k])) $display("FAIL bp_resume[%0d] got %0d want %0d", k, bus.out_ch, exp_ch[k]); else passed++;
    end
  endtask

  task automatic test_async_reset();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_ch !== 7'd0)
      $display("FAIL async_rst got v=%b d=%h ch=%0d want 0/0000/0", bus.out_valid, bus.out_data, bus.out_ch);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (bus.out_ch !== 7'd0 || bus.out_valid !== 1'b1) $display("FAIL rst_restart got ch=%0d v=%b want 0/1", bus.out_ch, bus.out_valid); else passed++;
    tick();
    total++; if (bus.out_ch !== 7'd5) $display("FAIL rst_restart2 got %0d want 5", bus.out_ch); else passed++;
  endtask

  task automatic test_random();
    bit [N_CH-1:0] exp_r;
    for (int n = 0; n < 400; n++) begin
      bus.mode      = 1'($urandom_range(0, 1));
      bus.sel       = SEL_W'($urandom_range(0, N_CH + 2));
      bus.in_valid  = N_CH'($urandom) & N_CH'($urandom);
      for (int i = 0; i < int'(N_CH); i++) bus.in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.err_clr   = ($urandom_range(0, 9) == 0);
`ifdef SEL_MUX_PARITY_EN
      for (int i = 0; i < int'(N_CH); i++) bus.in_par[i] = ^bus.in_data[i*WIDTH +: WIDTH];
`endif
      #1;
      model_ready(exp_r);
      total++; if (bus.in_ready !== exp_r) $display("FAIL rnd_in_ready[%0d] got %b want %b", n, bus.in_ready, exp_r); else passed++;
      tick();
      total++;
      if (bus.out_valid !== m_ov || bus.out_data !== m_od || bus.out_ch !== SEL_W'(m_och) || bus.sel_err !== m_err)
        $display("FAIL rnd_out[%0d] got v=%b d=%h ch=%0d e=%b want v=%b d=%h ch=%0d e=%b", n,
                 bus.out_valid, bus.out_data, bus.out_ch, bus.sel_err, m_ov, m_od, m_och, m_err);
      else passed++;
    end
    bus.err_clr = 1'b0;
  endtask

`ifdef SEL_MUX_PARITY_EN
  task automatic test_parity();
    bus.mode = 1'b0; bus.sel = 7'd1; bus.in_valid = '0; bus.out_ready = 1'b1; bus.err_clr = 1'b1;
    tick();
    total++; if (bus.par_err !== 1'b0) $display("FAIL par_clear got %b want 0", bus.par_err); else passed++;
    bus.err_clr = 1'b0;
    bus.in_data[1*WIDTH +: WIDTH] = 16'h0003;
    bus.in_par = 10'b0000000010;
    bus.in_valid = 10'b0000000010;
    tick();
    total++; if (bus.out_data !== 16'h0003) $display("FAIL par_data got %h want 0003", bus.out_data); else passed++;
    total++; if (bus.out_par !== 1'b0) $display("FAIL par_out got %b want 0", bus.out_par); else passed++;
    total++; if (bus.par_err !== 1'b1) $display("FAIL par_err got %b want 1", bus.par_err); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_sel_err();
    test_round_robin();
    test_back_pressure();
    test_async_reset();
    test_random();
`ifdef SEL_MUX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
